multicycle_ctrl: RTL and testbench

//  Moore-style control FSM that sequences a multicycle MIPS datapath over one shared memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 76 +++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/mc_out_decode.sv | 85 ++++++++
 rtl/multicycle_ctrl.sv | 84 ++++++++
 tb/tb_multicycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the multicycle MIPS controller.
package multicycle_ctrl_pkg;

   localparam int unsigned OPW    = 6;
   localparam int unsigned ALUOPW = 4;
   localparam int unsigned STW    = 4;

   localparam logic [OPW-1:0] OP_R    = 6'h00;
   localparam logic [OPW-1:0] OP_J    = 6'h02;
   localparam logic [OPW-1:0] OP_JAL  = 6'h03;
   localparam logic [OPW-1:0] OP_BEQ  = 6'h04;
   localparam logic [OPW-1:0] OP_BNE  = 6'h05;
   localparam logic [OPW-1:0] OP_ADDI = 6'h08;
   localparam logic [OPW-1:0] OP_SLTI = 6'h0A;
   localparam logic [OPW-1:0] OP_ANDI = 6'h0C;
   localparam logic [OPW-1:0] OP_ORI  = 6'h0D;
   localparam logic [OPW-1:0] OP_LW   = 6'h23;
   localparam logic [OPW-1:0] OP_SW   = 6'h2B;

   typedef enum logic [ALUOPW-1:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_FUNCT = 4'd2,
      ALU_AND   = 4'd3,
      ALU_OR    = 4'd4,
      ALU_SLT   = 4'd5
   } alu_op_e;

   typedef enum logic [STW-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EX     = 4'd6,
      S_R_WB     = 4'd7,
      S_I_EX     = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_TRAP     = 4'd12
   } state_e;

   // Full set of datapath controls produced each cycle.
   typedef struct packed {
      logic              pc_write;
      logic              pc_wr_cond;
      logic              branch_ne;
      logic              iord;
      logic              mem_read;
      logic              mem_write;
      logic              ir_write;
      logic [1:0]        mem_to_reg;
      logic [1:0]        reg_dst;
      logic              reg_write;
      logic              alu_src_a;
      logic [1:0]        alu_src_b;
      logic [ALUOPW-1:0] alu_op;
      logic [1:0]        pc_source;
   } ctrl_out_t;

   // ALU operation for the immediate-arithmetic class.
   function automatic alu_op_e imm_alu_op(input logic [OPW-1:0] op);
      alu_op_e res;
      res = ALU_ADD;
      case (op)
         OP_ANDI: res = ALU_AND;
         OP_ORI:  res = ALU_OR;
         OP_SLTI: res = ALU_SLT;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags in, control strobes and selects out.
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [OPW-1:0]    opcode;
   logic              zero;
   logic              mem_ready;
   logic              pc_write;
   logic              pc_wr_cond;
   logic              branch_ne;
   logic              iord;
   logic              mem_read;
   logic              mem_write;
   logic              ir_write;
   logic [1:0]        mem_to_reg;
   logic [1:0]        reg_dst;
   logic              reg_write;
   logic              alu_src_a;
   logic [1:0]        alu_src_b;
   logic [ALUOPW-1:0] alu_op;
   logic [1:0]        pc_source;
   logic              illegal;
   logic [STW-1:0]    state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_wr_cond, branch_ne, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_wr_cond, branch_ne, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal, state
   );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode: maps current state (plus memory handshake and reset) to the control word.
module mc_out_decode
   import multicycle_ctrl_pkg::*;
(
   input  state_e         state_i,
   input  logic [OPW-1:0] opcode_i,
   input  logic           mem_ready_i,
   input  logic           reset_i,
   output ctrl_out_t      ctrl_o
);

   // Control word per state; reset shows FETCH selects with every strobe held low.
   always_comb begin
      ctrl_o = '0;
      if (reset_i) begin
         ctrl_o.alu_src_b = 2'b01;
         ctrl_o.alu_op    = ALU_ADD;
      end else begin
         case (state_i)
            S_FETCH: begin
               ctrl_o.mem_read  = 1'b1;
               ctrl_o.alu_src_b = 2'b01;
               ctrl_o.alu_op    = ALU_ADD;
               ctrl_o.ir_write  = mem_ready_i;
               ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
               ctrl_o.alu_src_b = 2'b11;
               ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = 2'b10;
               ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
               ctrl_o.mem_read = 1'b1;
               ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
               ctrl_o.mem_write = 1'b1;
               ctrl_o.iord      = 1'b1;
            end
            S_R_EX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.reg_dst   = 2'b01;
            end
            S_I_EX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = 2'b10;
               ctrl_o.alu_op    = imm_alu_op(opcode_i);
            end
            S_I_WB: begin
               ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
               ctrl_o.alu_src_a  = 1'b1;
               ctrl_o.alu_op     = ALU_SUB;
               ctrl_o.pc_wr_cond = 1'b1;
               ctrl_o.pc_source  = 2'b01;
               ctrl_o.branch_ne  = (opcode_i == OP_BNE);
            end
            S_JUMP: begin
               ctrl_o.pc_write  = 1'b1;
               ctrl_o.pc_source = 2'b10;
               if (opcode_i == OP_JAL) begin
                  ctrl_o.reg_write  = 1'b1;
                  ctrl_o.reg_dst    = 2'b10;
                  ctrl_o.mem_to_reg = 2'b10;
               end
            end
            default: ctrl_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, sticky illegal flag and next-state logic.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input logic               clock,
   input logic               Reset,
   multicycle_ctrl_if.master ctrl
);

   state_e    state_q, state_d;
   logic      illegal_q;
   ctrl_out_t dec;
   logic      unused_zero;

   // Zero flag is consumed by the datapath's conditional PC load, not here.
   assign unused_zero = ctrl.zero;

   // Next-state selection; memory phases hold until the ready handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (ctrl.opcode)
               OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
               OP_R:                             state_d = S_R_EX;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EX;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_J, OP_JAL:                     state_d = S_JUMP;
               default:                          state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: state_d = (ctrl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (ctrl.mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:   state_d = S_FETCH;
         S_MEM_WR:   if (ctrl.mem_ready) state_d = S_FETCH;
         S_R_EX:     state_d = S_R_WB;
         S_R_WB:     state_d = S_FETCH;
         S_I_EX:     state_d = S_I_WB;
         S_I_WB:     state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // State and sticky trap flag; reset wins from any state.
   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP) illegal_q <= 1'b1;
      end
   end

   mc_out_decode u_out_decode (
      .state_i     (state_q),
      .opcode_i    (ctrl.opcode),
      .mem_ready_i (ctrl.mem_ready),
      .reset_i     (Reset),
      .ctrl_o      (dec)
   );

   assign ctrl.pc_write   = dec.pc_write;
   assign ctrl.pc_wr_cond = dec.pc_wr_cond;
   assign ctrl.branch_ne  = dec.branch_ne;
   assign ctrl.iord       = dec.iord;
   assign ctrl.mem_read   = dec.mem_read;
   assign ctrl.mem_write  = dec.mem_write;
   assign ctrl.ir_write   = dec.ir_write;
   assign ctrl.mem_to_reg = dec.mem_to_reg;
   assign ctrl.reg_dst    = dec.reg_dst;
   assign ctrl.reg_write  = dec.reg_write;
   assign ctrl.alu_src_a  = dec.alu_src_a;
   assign ctrl.alu_src_b  = dec.alu_src_b;
   assign ctrl.alu_op     = dec.alu_op;
   assign ctrl.pc_source  = dec.pc_source;
   assign ctrl.illegal    = illegal_q;
   assign ctrl.state      = STW'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase model, random wait states, reset and trap scenarios.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic clock = 1'b0;
   logic Reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   multicycle_ctrl_if ctrl ();

   multicycle_ctrl dut (
      .clock (clock),
      .Reset (Reset),
      .ctrl  (ctrl.master)
   );

   always #5 clock = ~clock;

   // Snapshot of every control output as one word.
   function automatic ctrl_out_t observe();
      ctrl_out_t o;
      o.pc_write   = ctrl.pc_write;
      o.pc_wr_cond = ctrl.pc_wr_cond;
      o.branch_ne  = ctrl.branch_ne;
      o.iord       = ctrl.iord;
      o.mem_read   = ctrl.mem_read;
      o.mem_write  = ctrl.mem_write;
      o.ir_write   = ctrl.ir_write;
      o.mem_to_reg = ctrl.mem_to_reg;
      o.reg_dst    = ctrl.reg_dst;
      o.reg_write  = ctrl.reg_write;
      o.alu_src_a  = ctrl.alu_src_a;
      o.alu_src_b  = ctrl.alu_src_b;
      o.alu_op     = ctrl.alu_op;
      o.pc_source  = ctrl.pc_source;
      return o;
   endfunction

   // Expected control word, taken straight from the per-state output table.
   function automatic ctrl_out_t spec_out(input state_e s, input logic [5:0] op,
                                          input logic rdy, input logic rst);
      ctrl_out_t o;
      o = '0;
      if (rst) begin
         o.alu_src_b = 2'b01;
         return o;
      end
      case (s)
         S_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         S_DECODE:   o.alu_src_b = 2'b11;
         S_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         S_MEM_RD:   begin o.mem_read = 1; o.iord = 1; end
         S_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
         S_MEM_WR:   begin o.mem_write = 1; o.iord = 1; end
         S_R_EX:     begin o.alu_src_a = 1; o.alu_op = 4'd2; end
         S_R_WB:     begin o.reg_write = 1; o.reg_dst = 2'b01; end
         S_I_EX: begin
            o.alu_src_a = 1; o.alu_src_b = 2'b10;
            if (op == 6'h0C) o.alu_op = 4'd3;
            else if (op == 6'h0D) o.alu_op = 4'd4;
            else if (op == 6'h0A) o.alu_op = 4'd5;
            else o.alu_op = 4'd0;
         end
         S_I_WB:     o.reg_write = 1;
         S_BRANCH: begin
            o.alu_src_a = 1; o.alu_op = 4'd1; o.pc_wr_cond = 1; o.pc_source = 2'b01;
            o.branch_ne = (op == 6'h05);
         end
         S_JUMP: begin
            o.pc_write = 1; o.pc_source = 2'b10;
            if (op == 6'h03) begin o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   // Cycle count per instruction with memory always ready.
   function automatic int base_latency(input logic [5:0] op);
      case (op)
         6'h23:                      return 5;
         6'h00, 6'h2B, 6'h08, 6'h0A,
         6'h0C, 6'h0D:               return 4;
         6'h04, 6'h05, 6'h02, 6'h03: return 3;
         default:                    return 0;
      endcase
   endfunction

   function automatic bit is_wait_phase(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

   // Runs one instruction from FETCH, checking state, outputs and total latency.
   task automatic run_instr(input logic [5:0] op, input bit rand_ready, input string tag);
      state_e    ph[$];
      int        cycles = 0;
      int        stalls = 0;
      int        run;
      logic      rdy;
      ctrl_out_t e_o, g_o;
      ph.push_back(S_FETCH);
      ph.push_back(S_DECODE);
      case (op)
         6'h23: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_RD); ph.push_back(S_MEM_WB); end
         6'h2B: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_WR); end
         6'h00: begin ph.push_back(S_R_EX); ph.push_back(S_R_WB); end
         6'h08, 6'h0A, 6'h0C, 6'h0D: begin ph.push_back(S_I_EX); ph.push_back(S_I_WB); end
         6'h04, 6'h05: ph.push_back(S_BRANCH);
         6'h02, 6'h03: ph.push_back(S_JUMP);
         default: ;
      endcase
      ctrl.opcode = op;
      foreach (ph[i]) begin
         run = 0;
         forever begin
            rdy = 1'b1;
            if (rand_ready && run < 4) rdy = ($urandom_range(0, 3) != 0);
            ctrl.mem_ready = rdy;
            #1;
            n_cmp++;
            if (ctrl.state !== STW'(ph[i])) begin
               n_bad++;
               $display("FAIL %s state cyc=%0d got=%0d exp=%0d", tag, cycles, ctrl.state, ph[i]);
            end
            e_o = spec_out(ph[i], op, rdy, 1'b0);
            g_o = observe();
            n_cmp++;
            if (g_o !== e_o) begin
               n_bad++;
               $display("FAIL %s outputs st=%0d got=%h exp=%h", tag, ph[i], g_o, e_o);
            end
            n_cmp++;
            if (ctrl.illegal !== 1'b0) begin
               n_bad++;
               $display("FAIL %s illegal got=%b exp=0", tag, ctrl.illegal);
            end
            cycles++;
            @(posedge clock); #1;
            if (is_wait_phase(ph[i]) && !rdy) begin
               stalls++;
               run++;
            end else begin
               break;
            end
         end
      end
      if (base_latency(op) != 0) begin
         n_cmp++;
         if (cycles !== base_latency(op) + stalls) begin
            n_bad++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, cycles, base_latency(op) + stalls);
         end
      end
   endtask

   task automatic test_lw();
      run_instr(6'h23, 1'b0, "lw");
   endtask

   task automatic test_fetch_stall();
      int pw = 0, iw = 0, held = 0;
      ctrl.opcode = 6'h00;
      for (int c = 0; c < 3; c++) begin
         ctrl.mem_ready = (c == 2);
         #1;
         if (ctrl.state === STW'(S_FETCH)) held++;
         if (ctrl.pc_write === 1'b1) pw++;
         if (ctrl.ir_write === 1'b1) iw++;
         if (c < 2) begin
            n_cmp++;
            if (ctrl.pc_write !== 1'b0 || ctrl.ir_write !== 1'b0) begin
               n_bad++;
               $display("FAIL stall_strobe cyc=%0d got pw=%b iw=%b exp 0", c, ctrl.pc_write, ctrl.ir_write);
            end
         end
         @(posedge clock); #1;
      end
      n_cmp++;
      if (held !== 3 || pw !== 1 || iw !== 1) begin
         n_bad++;
         $display("FAIL stall_counts got held=%0d pw=%0d iw=%0d exp 3/1/1", held, pw, iw);
      end
      n_cmp++;
      if (ctrl.state !== STW'(S_DECODE)) begin
         n_bad++;
         $display("FAIL stall_next got=%0d exp=%0d", ctrl.state, S_DECODE);
      end
      ctrl.mem_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (ctrl.state !== STW'(S_FETCH)) begin
         n_bad++;
         $display("FAIL stall_done got=%0d exp=%0d", ctrl.state, S_FETCH);
      end
   endtask

   task automatic test_branches();
      run_instr(6'h04, 1'b0, "beq");
      run_instr(6'h05, 1'b0, "bne");
   endtask

   task automatic test_jal();
      run_instr(6'h03, 1'b0, "jal");
      run_instr(6'h02, 1'b0, "j");
   endtask

   task automatic test_reset_mid_write();
      ctrl_out_t e_o;
      ctrl.opcode    = 6'h2B;
      ctrl.mem_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      ctrl.mem_ready = 1'b0;
      #1;
      e_o = spec_out(S_MEM_WR, 6'h2B, 1'b0, 1'b0);
      n_cmp++;
      if (ctrl.state !== STW'(S_MEM_WR) || observe() !== e_o) begin
         n_bad++;
         $display("FAIL memwr_pre got st=%0d out=%h exp st=%0d out=%h", ctrl.state, observe(), S_MEM_WR, e_o);
      end
      @(posedge clock); #1;
      Reset = 1'b1;
      #1;
      e_o = spec_out(S_FETCH, 6'h2B, 1'b0, 1'b1);
      n_cmp++;
      if (ctrl.mem_write !== 1'b0 || observe() !== e_o) begin
         n_bad++;
         $display("FAIL memwr_reset got mw=%b out=%h exp mw=0 out=%h", ctrl.mem_write, observe(), e_o);
      end
      @(posedge clock); #1;
      Reset = 1'b0;
      n_cmp++;
      if (ctrl.state !== STW'(S_FETCH)) begin
         n_bad++;
         $display("FAIL memwr_after got=%0d exp=%0d", ctrl.state, S_FETCH);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [11];
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
      for (int k = 0; k < 40; k++) begin
         ctrl.zero = 1'($urandom_range(0, 1));
         run_instr(ops[$urandom_range(0, 10)], 1'b1, "rand");
      end
   endtask

   task automatic test_trap();
      run_instr(6'h3F, 1'b0, "trap_entry");
      for (int c = 0; c < 10; c++) begin
         ctrl.mem_ready = 1'($urandom_range(0, 1));
         #1;
         n_cmp++;
         if (ctrl.state !== STW'(S_TRAP) || ctrl.illegal !== 1'b1 || observe() !== ctrl_out_t'(0)) begin
            n_bad++;
            $display("FAIL trap cyc=%0d got st=%0d ill=%b out=%h exp st=%0d ill=1 out=0",
                     c, ctrl.state, ctrl.illegal, observe(), S_TRAP);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      ctrl_out_t e_o;
      e_o = spec_out(S_FETCH, 6'h3F, 1'b1, 1'b1);
      Reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         ctrl.mem_ready = 1'b1;
         #1;
         n_cmp++;
         if (observe() !== e_o) begin
            n_bad++;
            $display("FAIL reset_out cyc=%0d got=%h exp=%h", c, observe(), e_o);
         end
         @(posedge clock); #1;
         n_cmp++;
         if (ctrl.state !== STW'(S_FETCH) || ctrl.illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state cyc=%0d got st=%0d ill=%b exp st=%0d ill=0",
                     c, ctrl.state, ctrl.illegal, S_FETCH);
         end
      end
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (ctrl.mem_read !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release mem_read got=%b exp=1", ctrl.mem_read);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      Reset          = 1'b1;
      ctrl.opcode    = 6'h00;
      ctrl.zero      = 1'b0;
      ctrl.mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      Reset = 1'b0;
      test_lw();
      test_fetch_stall();
      test_branches();
      test_jal();
      run_instr(6'h2B, 1'b0, "sw");
      run_instr(6'h0D, 1'b0, "ori");
      test_reset_mid_write();
      test_random();
      test_trap();
      test_reset();
      run_instr(6'h0A, 1'b0, "slti_after_reset");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
